// File: rtl/det_mem_arbiter.sv
// det_mem_arbiter
//   Round-robin arbiter that lets two determinant engines share one matrix
//   memory port. Ownership is granted per burst, so an engine can stream a
//   whole matrix read or write back its result without interleaving. Every
//   memory-side signal leaves this block from a register.
//
// Optional feature macro: DET_ARB_TIMEOUT_EN
//   When defined, a burst that reaches MAX_BURST granted cycles while the
//   other engine is waiting is forcibly released. When undefined, a burst
//   lasts until the owner flags its final access or drops its request.
//
// Ports:
//   clk, reset               rising-edge clock; asynchronous active-low reset
//   req0/1                   requester k wants memory ownership
//   rd0/1, wr0/1             read/write strobes from requester k
//   last0/1                  current access is the final one of the burst
//   i0/j0, i1/j1             row/column address from requester k
//   wdata0/1                 2N-bit write data from requester k
//   gnt0/1                   registered ownership grant (one-hot or zero)
//   rdata, rvalid0/1         registered read data and per-requester valid
//   mem_read, mem_write      registered memory strobes
//   mem_i, mem_j, mem_wdata  registered memory address and write data
//   mem_rdata                memory read data (combinational from mem_i/mem_j)
//   busy                     a grant is active
module det_mem_arbiter #(
   parameter int N         = 20,
   parameter int MAX_BURST = 64,
   parameter int CW        = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0,
   input  logic           req1,
   input  logic           rd0,
   input  logic           rd1,
   input  logic           wr0,
   input  logic           wr1,
   input  logic           last0,
   input  logic           last1,
   input  logic [N-1:0]   i0,
   input  logic [N-1:0]   j0,
   input  logic [N-1:0]   i1,
   input  logic [N-1:0]   j1,
   input  logic [2*N-1:0] wdata0,
   input  logic [2*N-1:0] wdata1,
   output logic           gnt0,
   output logic           gnt1,
   output logic [N-1:0]   rdata,
   output logic           rvalid0,
   output logic           rvalid1,
   output logic           mem_read,
   output logic           mem_write,
   output logic [N-1:0]   mem_i,
   output logic [N-1:0]   mem_j,
   output logic [2*N-1:0] mem_wdata,
   input  logic [N-1:0]   mem_rdata,
   output logic           busy
);

   // The burst counter must be able to represent MAX_BURST-1 without wrapping.
   if ((2 ** CW) <= MAX_BURST) begin : g_cw_check
      $error("det_mem_arbiter: CW too narrow for MAX_BURST");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   state_t          state_reg, state_next;
   logic            ptr_reg, ptr_next;       // requester favoured on a tie
   logic [CW-1:0]   cnt_reg;                 // cycles spent in the current burst

   logic            own0, own1;
   logic            sel_rd, sel_wr, sel_last, sel_req, other_req;
   logic [N-1:0]    sel_i, sel_j;
   logic [2*N-1:0]  sel_wdata;
   logic            acc, timeout, release_now;

   logic            mem_read_reg, mem_write_reg;
   logic [N-1:0]    mem_i_reg, mem_j_reg;
   logic [2*N-1:0]  mem_wdata_reg;
   logic            rd_owner_reg;            // requester that issued the read in flight
   logic [N-1:0]    rdata_reg;
   logic            rvalid0_reg, rvalid1_reg;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         ptr_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         // Cleared on every entry into an owned state, including a direct
         // OWN0 <-> OWN1 hand-over.
         if (state_next != IDLE && state_next != state_reg)
            cnt_reg <= '0;
         else if ((own0 | own1) && cnt_reg != '1)
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (req0 && (!req1 || !ptr_reg))
               state_next = OWN0;
            else if (req1)
               state_next = OWN1;
         end
         OWN0, OWN1: begin
            if (release_now) begin
               ptr_next   = own0;    // pointer moves to the other requester
               state_next = other_req ? (own0 ? OWN1 : OWN0) : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- output / owner-select logic ----------------
   always_comb begin
      own0      = (state_reg == OWN0);
      own1      = (state_reg == OWN1);
      sel_rd    = 1'b0;
      sel_wr    = 1'b0;
      sel_last  = 1'b0;
      sel_req   = 1'b0;
      other_req = 1'b0;
      sel_i     = i0;
      sel_j     = j0;
      sel_wdata = wdata0;
      if (own0) begin
         sel_rd    = rd0;
         sel_wr    = wr0;
         sel_last  = last0;
         sel_req   = req0;
         other_req = req1;
      end else if (own1) begin
         sel_rd    = rd1;
         sel_wr    = wr1;
         sel_last  = last1;
         sel_req   = req1;
         other_req = req0;
         sel_i     = i1;
         sel_j     = j1;
         sel_wdata = wdata1;
      end
      acc = sel_rd | sel_wr;
`ifdef DET_ARB_TIMEOUT_EN
      timeout = (own0 | own1) && (cnt_reg == CW'(MAX_BURST - 1)) && other_req;
`else
      timeout = 1'b0;
`endif
      // The access of the releasing cycle is still forwarded by the datapath.
      release_now = (acc & sel_last) | ~sel_req | timeout;
      gnt0 = own0;
      gnt1 = own1;
      busy = own0 | own1;
   end

   // ---------------- memory-side datapath ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         mem_i_reg     <= '0;
         mem_j_reg     <= '0;
         mem_wdata_reg <= '0;
         rd_owner_reg  <= 1'b0;
         rdata_reg     <= '0;
         rvalid0_reg   <= 1'b0;
         rvalid1_reg   <= 1'b0;
      end else begin
         // A simultaneous read and write forwards only the write.
         mem_read_reg  <= acc & ~sel_wr;
         mem_write_reg <= sel_wr;
         if (acc) begin
            mem_i_reg     <= sel_i;
            mem_j_reg     <= sel_j;
            mem_wdata_reg <= sel_wdata;
            rd_owner_reg  <= own1;
         end
         // Second stage: completes even if the issuing grant has since dropped.
         rvalid0_reg <= mem_read_reg & ~rd_owner_reg;
         rvalid1_reg <= mem_read_reg & rd_owner_reg;
         if (mem_read_reg)
            rdata_reg <= mem_rdata;
      end
   end

   assign mem_read  = mem_read_reg;
   assign mem_write = mem_write_reg;
   assign mem_i     = mem_i_reg;
   assign mem_j     = mem_j_reg;
   assign mem_wdata = mem_wdata_reg;
   assign rdata     = rdata_reg;
   assign rvalid0   = rvalid0_reg;
   assign rvalid1   = rvalid1_reg;

endmodule

// File: tb/tb_det_mem_arbiter.sv
// Testbench for det_mem_arbiter: table-driven arbitration vectors, hand-written
// corner-case sequences, and a scoreboard that checks every memory access and
// every read return against what the driver issued.
module tb_det_mem_arbiter;
   localparam int N = 20;
   localparam int CW = 8;
`ifdef DET_ARB_TIMEOUT_EN
   localparam int MB = 8;
`else
   localparam int MB = 64;
`endif

   logic clk, reset;
   logic req0, req1, rd0, rd1, wr0, wr1, last0, last1;
   logic [N-1:0] i0, j0, i1, j1;
   logic [2*N-1:0] wdata0, wdata1;
   logic gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy;
   logic [N-1:0] rdata, mem_i, mem_j, mem_rdata;
   logic [2*N-1:0] mem_wdata;

   int checks = 0;
   int errors = 0;

   det_mem_arbiter #(.N(N), .MAX_BURST(MB), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
      .last0(last0), .last1(last1), .i0(i0), .j0(j0), .i1(i1), .j1(j1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
      .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .mem_read(mem_read), .mem_write(mem_write), .mem_i(mem_i), .mem_j(mem_j),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents model.
   function automatic logic [N-1:0] rd_fn(input logic [N-1:0] a, input logic [N-1:0] b);
      if (a == 20'd2 && b == 20'd3) return 20'h01234;
      return (a * 20'd37 + b) ^ 20'h5A5A5;
   endfunction
   assign mem_rdata = mem_read ? rd_fn(mem_i, mem_j) : '0;

   typedef struct { logic is_wr; logic [N-1:0] i; logic [N-1:0] j; logic [2*N-1:0] wd; } mop_t;
   typedef struct { logic port; logic [N-1:0] d; } rv_t;
   mop_t mq[$];
   rv_t  rq[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push_acc(input logic port, input logic r, input logic w,
                           input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] d);
      mop_t m;
      rv_t  v;
      m.is_wr = w; m.i = a; m.j = b; m.wd = d;
      mq.push_back(m);
      if (r && !w) begin
         v.port = port; v.d = rd_fn(a, b);
         rq.push_back(v);
      end
   endtask

   // Registers expected effects of the strobes currently driven, then advances
   // one cycle; returns at posedge+1.
   task automatic tick();
      if (gnt0 && (rd0 || wr0)) push_acc(1'b0, rd0, wr0, i0, j0, wdata0);
      if (gnt1 && (rd1 || wr1)) push_acc(1'b1, rd1, wr1, i1, j1, wdata1);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0; last0 = 0; last1 = 0;
   endtask

   // Scoreboard / monitor, sampled on the falling edge.
   always @(negedge clk) begin
      mop_t m;
      rv_t  v;
      if (reset) begin
         chk("gnt_onehot", {63'd0, gnt0 & gnt1}, 64'd0);
         if (mem_read || mem_write) begin
            if (mq.size() == 0) begin
               checks++; errors++;
               $display("FAIL mem_unexpected: got rd=%0b wr=%0b want no access", mem_read, mem_write);
            end else begin
               m = mq.pop_front();
               chk("mem_op", {22'd0, mem_write, mem_read, mem_i, mem_j},
                   {22'd0, m.is_wr, ~m.is_wr, m.i, m.j});
               if (m.is_wr) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m.wd});
            end
         end
         if (rvalid0 || rvalid1) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL rvalid_unexpected: got rv0=%0b rv1=%0b want none", rvalid0, rvalid1);
            end else begin
               v = rq.pop_front();
               chk("rvalid_port", {62'd0, rvalid1, rvalid0}, v.port ? 64'd2 : 64'd1);
               chk("rdata", {44'd0, rdata}, {44'd0, v.d});
            end
         end
      end
   end

   typedef struct packed { logic r0, r1, rd0, l0, rd1, l1, g0, g1; } vec_t;
   vec_t vt [10];

   function automatic vec_t mk(input logic r0, r1, a0, l0, a1, l1, g0, g1);
      vec_t x;
      x.r0 = r0; x.r1 = r1; x.rd0 = a0; x.l0 = l0; x.rd1 = a1; x.l1 = l1; x.g0 = g0; x.g1 = g1;
      return x;
   endfunction

   initial begin
      int cnt, bc, bursts;
      int owners[$];
      clear_in();
      i0 = 0; j0 = 0; i1 = 0; j1 = 0; wdata0 = 0; wdata1 = 0;
      reset = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", {62'd0, gnt0, gnt1}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_mem", {mem_read, mem_write, mem_i, mem_j}, 64'd0);
      chk("rst_rd", {rvalid0, rvalid1, rdata}, 64'd0);
      reset = 1;
      tick();

      // ---- arbitration table: inputs for one cycle, grant after the edge ----
      //           r0 r1 rd0 l0 rd1 l1  g0 g1
      vt[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
      vt[1] = mk(0, 1, 0, 0, 0, 0, 0, 1);
      vt[2] = mk(0, 1, 0, 0, 1, 1, 0, 0);
      vt[3] = mk(1, 1, 0, 0, 0, 0, 1, 0);
      vt[4] = mk(0, 1, 0, 0, 0, 0, 0, 1);
      vt[5] = mk(1, 1, 0, 0, 1, 1, 1, 0);
      vt[6] = mk(1, 0, 1, 1, 0, 0, 0, 0);
      vt[7] = mk(1, 1, 0, 0, 0, 0, 0, 1);
      vt[8] = mk(1, 0, 0, 0, 0, 0, 1, 0);
      vt[9] = mk(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         req0 = vt[k].r0; req1 = vt[k].r1; rd0 = vt[k].rd0; last0 = vt[k].l0;
         rd1 = vt[k].rd1; last1 = vt[k].l1;
         i0 = N'(k); j0 = N'(k + 1); i1 = N'(k + 2); j1 = N'(k + 3);
         tick();
         chk($sformatf("vec%0d_gnt", k), {62'd0, gnt0, gnt1}, {62'd0, vt[k].g0, vt[k].g1});
         chk($sformatf("vec%0d_busy", k), {63'd0, busy}, {63'd0, vt[k].g0 | vt[k].g1});
      end
      clear_in();
      tick();

      // ---- single-owner read with fixed latency ----
      req0 = 1; tick();
      rd0 = 1; i0 = 2; j0 = 3; tick();
      chk("sr_mem", {mem_read, mem_i, mem_j}, {1'b1, 20'd2, 20'd3});
      rd0 = 0; tick();
      chk("sr_rdata", {rvalid0, rvalid1, rdata}, {2'b10, 20'h01234});
      rd0 = 1; last0 = 1; i0 = 4; tick();
      clear_in(); tick();

      // ---- write wins over read; no rvalid ----
      req1 = 1; tick();
      rd1 = 1; wr1 = 1; last1 = 1; i1 = 5; j1 = 6; wdata1 = 40'h00000ABCDE; tick();
      chk("wp_strobe", {mem_write, mem_read}, 64'd2);
      chk("wp_data", {24'd0, mem_wdata}, 64'h00000ABCDE);
      clear_in();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("wp_no_rvalid1", {63'd0, rvalid1}, 64'd0);
      end

      // ---- non-owner strobes are ignored ----
      req0 = 1; tick();
      req1 = 1; rd1 = 1; wr1 = 1; wdata1 = 40'h1122334455; i1 = 9; j1 = 9;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("no_strobe", {mem_read, mem_write, gnt1}, 64'd0);
      end
      rd0 = 1; last0 = 1; i0 = 7; j0 = 8; tick();
      chk("no_handover", {62'd0, gnt0, gnt1}, 64'd1);
      req0 = 0; rd0 = 0; last0 = 0; last1 = 1; tick();
      clear_in(); repeat (2) tick();

      // ---- reset mid-burst with reads in flight ----
      req0 = 1; tick();
      for (int k = 0; k < 3; k++) begin
         rd0 = 1; i0 = N'(10 + k); j0 = 1; tick();
      end
      #1 reset = 0;
      #1;
      mq.delete(); rq.delete();
      chk("ar_gnt", {61'd0, gnt0, gnt1, busy}, 64'd0);
      chk("ar_mem", {mem_read, mem_write, mem_i, mem_j}, 64'd0);
      chk("ar_wdata", {24'd0, mem_wdata}, 64'd0);
      chk("ar_rd", {rvalid0, rvalid1, rdata}, 64'd0);
      clear_in(); req0 = 1; req1 = 1;
      repeat (2) @(posedge clk);
      #1 reset = 1;
      tick();
      chk("ar_first_gnt", {62'd0, gnt0, gnt1}, 64'd2);
      chk("ar_no_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);

      // ---- fairness: 4-read bursts alternate with no idle cycle ----
      bc = 0; bursts = 0;
      for (int c = 0; c < 40 && bursts < 4; c++) begin
         chk("fair_busy", {63'd0, busy}, 64'd1);
         if (owners.size() == 0 || owners[$] != (gnt1 ? 1 : 0)) owners.push_back(gnt1 ? 1 : 0);
         rd0 = gnt0; rd1 = gnt1;
         last0 = gnt0 && bc == 3; last1 = gnt1 && bc == 3;
         i0 = N'(c); j0 = 1; i1 = N'(c); j1 = 2;
         if (gnt0 || gnt1) begin
            if (bc == 3) begin bc = 0; bursts++; end
            else bc++;
         end
         tick();
      end
      chk("fair_bursts", 64'(bursts), 64'd4);
      chk("fair_count", 64'(owners.size()), 64'd4);
      for (int k = 0; k < 4 && k < owners.size(); k++)
         chk($sformatf("fair_owner%0d", k), 64'(owners[k]), 64'(k % 2));
      chk("fair_next", {62'd0, gnt0, gnt1}, 64'd2);
      clear_in(); repeat (3) tick();

      // ---- long burst: forced rotation only with the timeout feature ----
      req0 = 1; tick();
      req1 = 1; cnt = 0;
      for (int c = 0; c < 110; c++) begin
         if (!gnt0) break;
         cnt++;
         rd0 = 1; i0 = N'(c); j0 = 5;
         tick();
      end
      rd0 = 0;
`ifdef DET_ARB_TIMEOUT_EN
      chk("to_cycles", 64'(cnt), 64'd8);
      chk("to_handover", {62'd0, gnt0, gnt1}, 64'd1);
      req0 = 0; rd1 = 1; last1 = 1; i1 = 3; j1 = 3; tick();
`else
      chk("to_cycles", 64'(cnt), 64'd110);
      chk("to_hold", {62'd0, gnt0, gnt1}, 64'd2);
      req1 = 0; rd0 = 1; last0 = 1; tick();
`endif
      clear_in(); repeat (4) tick();

      chk("mq_empty", 64'(mq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/det_mem_arbiter.md
Name: det_mem_arbiter

Overview:
- Round-robin arbiter that shares one matrix memory port (i/j addressed, N-bit read data, 2N-bit write data) between two determinant engines.
- Grants whole bursts, so an engine can stream a full matrix read, or write its result, without interleaving.
- Registers all memory-side signals.
- Sits between the engines and the matrix memory in the determinant subsystem.

Parameters:
N, 20, index width and read-data width; write data is 2N.
MAX_BURST, 64, granted cycles before forced rotation (only with DET_ARB_TIMEOUT_EN).
CW, 8, width of the burst counter; must satisfy 2^CW > MAX_BURST.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req0, req1  in  1  requester k wants memory ownership
rd0, rd1  in  1  read strobe from requester k
wr0, wr1  in  1  write strobe from requester k
last0, last1  in  1  qualifies the current rd/wr as the final access of the burst
i0, j0, i1, j1  in  N  row/column address from requester k
wdata0, wdata1  in  2N  write data from requester k
gnt0, gnt1  out  1  ownership grant (registered, one-hot or zero)
rdata  out  N  registered read data, shared by both requesters
rvalid0, rvalid1  out  1  rdata valid for requester k
mem_read, mem_write  out  1  registered memory strobes
mem_i, mem_j  out  N  registered memory address
mem_wdata  out  2N  registered memory write data
mem_rdata  in  N  memory read data, combinational from mem_i/mem_j while mem_read=1
busy  out  1  a grant is active

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, priority pointer = 0, burst counter = 0, all outputs 0.
- In-flight reads are discarded on reset; no rvalid is issued after reset releases.
- States:
  - IDLE: waiting for a request.
  - OWN0 / OWN1: gnt0 / gnt1 high.
- IDLE, arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester at the pointer wins.
  - The winner's gnt rises on the next edge; minimum request-to-grant latency is 1 cycle.
- OWNk, forwarding:
  - Each cycle with gntk=1 and rdk or wrk high, the access is registered onto mem_*.
  - mem_* are valid the following cycle for exactly one cycle; otherwise mem_read=mem_write=0.
  - mem_i, mem_j and mem_wdata hold their last values when no access is forwarded.
- rdk and wrk both high: the write is forwarded, the read is dropped, no rvalid.
- Strobes from the non-owner are ignored entirely; they must be held until granted.
- Read latency: rdk at cycle t gives mem_read at t+1, and rdata = mem_rdata with rvalidk=1 at t+2.
- Back-to-back reads sustain one read per cycle.
- Release conditions (in OWNk):
  - An access with lastk=1 is forwarded, or
  - reqk=0.
- On release, the pointer moves to the other requester.
- On release, the next state is OWN(other) if the other req is high (no idle bubble; gnt switches in one edge), otherwise IDLE.
- The final access is always forwarded before gnt drops.
- Outstanding rvalid for the releasing requester still completes after its gnt drops.
- Burst counter: cleared on entering OWNk; increments each OWNk cycle; saturates at 2^CW-1.
- busy = gnt0 | gnt1.
- gnt0 and gnt1 are never high together.

Optional Feature:
DET_ARB_TIMEOUT_EN
- Defined: when the burst counter reaches MAX_BURST-1 and the other req is high, ownership is forcibly released.
  - This behaves as a release: the access in that cycle is forwarded, the pointer flips, and the other requester is granted next.
  - The preempted requester re-requests normally and resumes from its own address state.
- Not defined: no forced release; a burst lasts until last or req drop. MAX_BURST is ignored.

Test Plan:
- Reset: drive reset=0 mid-burst with 3 reads outstanding -> all outputs 0 immediately; after release, no rvalid, and req0 and req1 together give gnt0 first.
- Single owner read: req0; then rd0 with i0=2, j0=3; mem_rdata=0x1234 -> mem_read=1 with mem_i=2, mem_j=3 one cycle after rd0; rdata=0x1234 and rvalid0=1 two cycles after rd0.
- Fairness: req0 and req1 both held; each bursts 4 reads ending with last -> grants alternate 0,1,0,1 with no IDLE cycle between bursts.
- Write priority: owner asserts rd1=wr1=1 with wdata1=0x00000ABCDE -> mem_write=1 with that data, mem_read=0, rvalid1 never rises.
- Non-owner ignored: gnt0 active, rd1=1 and wr1=1 for 5 cycles -> no mem strobe attributable to requester 1; gnt1 only after last0.
- Timeout (macro defined, MAX_BURST=8): req0 streams without last while req1 is held -> gnt0 drops after 8 granted cycles and gnt1 rises the next edge. Without the macro, gnt0 holds for 100+ cycles.
